fios_mm_seq: RTL

- Parametrised word-serial FIOS Montgomery multiplier computing RES = a·b·R⁻¹ mod p, where R = 2^(W·s).
- Word width W is a compile-time parameter; operand length s is chosen per operation, up to S_MAX.
- One combined multiply-accumulate step per clock; operands live in internal buffers loaded over a write port; result words are streamed out.
- Next-generation, DSP-independent successor to the fixed-s FIOS datapath; used for variable-length moduli.

---
 rtl/fios_seq_pkg.sv | 27 ++
 rtl/fios_pe_step.sv | 40 ++++
 rtl/fios_mm_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fios_seq_pkg.sv
// fios_seq_pkg: shared types and constants for the word-serial FIOS
// Montgomery multiplier (fios_mm_seq).
//   state_e  - sequencer states
//   OP_*     - operand buffer selects for the write port
//   carry_w  - width of the step carry for a given word width
package fios_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MCOMP = 3'd1,
    LOOP  = 3'd2,
    TAIL  = 3'd3,
    SUB   = 3'd4,
    OUT   = 3'd5
  } state_e;

  localparam logic [1:0] OP_A = 2'd0;
  localparam logic [1:0] OP_B = 2'd1;
  localparam logic [1:0] OP_P = 2'd2;

  // t + a*b + m*p + C with every term below 2^W (C below 2^(W+2)) stays
  // below 2^(2W+2), so the carry above the low word needs W+2 bits.
  function automatic int carry_w(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/fios_pe_step.sv
// fios_pe_step: one combinational FIOS multiply-accumulate step.
//   (c_o, s_o) = t_i + a_i*b_i + m_i*p_i + c_i
// Ports:
//   t_i, a_i, b_i, m_i, p_i : W-bit input words
//   c_i                     : CW-bit incoming carry
//   s_o                     : W-bit low word of the sum
//   c_o                     : CW-bit outgoing carry (sum >> W)
module fios_pe_step #(
  parameter int W  = 17,
  parameter int CW = W + 2
) (
  input  logic [W-1:0]  t_i,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  input  logic [W-1:0]  m_i,
  input  logic [W-1:0]  p_i,
  input  logic [CW-1:0] c_i,
  output logic [W-1:0]  s_o,
  output logic [CW-1:0] c_o
);

  localparam int SUMW = W + CW;

  logic [2*W-1:0]  ab;
  logic [2*W-1:0]  mp;
  logic [SUMW-1:0] sum;

  always_comb begin
    ab  = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
    mp  = {{W{1'b0}}, m_i} * {{W{1'b0}}, p_i};
    sum = {{CW{1'b0}}, t_i}
        + {{(SUMW-2*W){1'b0}}, ab}
        + {{(SUMW-2*W){1'b0}}, mp}
        + {{W{1'b0}}, c_i};
  end

  assign s_o = sum[W-1:0];
  assign c_o = sum[SUMW-1:W];

endmodule

// File: rtl/fios_mm_seq.sv
// fios_mm_seq: word-serial FIOS Montgomery multiplier, RES = a*b*R^-1 mod p,
// R = 2^(W*s), with s (1..S_MAX) chosen per operation.
// Optional final subtraction enabled by defining FIOS_FINAL_SUB_EN; without
// it the result lies in [0, 2p).
// Ports:
//   clock_i, reset_i     : clock, synchronous active-high reset
//   start_i, s_i         : launch and word count (captured on accepted start)
//   p_prime_0_i          : -p^-1 mod 2^W (captured on accepted start)
//   op_we_i, op_sel_i,
//   op_addr_i, op_data_i : operand buffer write port (idle only)
//   busy_o               : accepted start until the cycle after done_o
//   RES_valid_o, RES_o   : result word stream, LSW first
//   done_o               : pulse with the last result word
module fios_mm_seq
  import fios_seq_pkg::*;
#(
  parameter int W     = 17,
  parameter int S_MAX = 8,
  localparam int SW   = $clog2(S_MAX + 1),
  localparam int AW   = $clog2(S_MAX)
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [SW-1:0] s_i,
  input  logic [W-1:0]  p_prime_0_i,
  input  logic          op_we_i,
  input  logic [1:0]    op_sel_i,
  input  logic [AW-1:0] op_addr_i,
  input  logic [W-1:0]  op_data_i,
  output logic          busy_o,
  output logic          RES_valid_o,
  output logic [W-1:0]  RES_o,
  output logic          done_o
);

  localparam int CW = carry_w(W);

  // Operand buffers: written only while idle, never reset.
  logic [S_MAX-1:0][W-1:0] a_q, b_q, p_q;

  state_e                  state_q, state_d;
  logic [SW-1:0]           s_q, s_d;
  logic [W-1:0]            pp0_q, pp0_d;
  logic [SW-1:0]           i_q, i_d;
  logic [SW-1:0]           j_q, j_d;     // inner word index, reused by SUB/OUT
  logic [W-1:0]            m_q, m_d;
  logic [CW-1:0]           c_q, c_d;
  logic [S_MAX-1:0][W-1:0] t_q, t_d;     // t[0..s-1]
  logic [1:0]              ttop_q, ttop_d; // t[s]
  logic                    busy_q, busy_d;
  logic                    vld_q, vld_d;
  logic [W-1:0]            res_q, res_d;
  logic                    done_q, done_d;

`ifdef FIOS_FINAL_SUB_EN
  logic [S_MAX-1:0][W-1:0] d_q, d_d;     // t - p scratch
  logic                    brw_q, brw_d;
  logic                    use_d_q, use_d_d;
  logic [W:0]              diff;
`endif

  logic [AW-1:0] ix, jx, jm1, sm1x;
  logic [SW-1:0] s_m1;
  logic          start_ok;

  logic [W-1:0]  pe_t, pe_a, pe_b, pe_m, pe_p, pe_s;
  logic [CW-1:0] pe_c, pe_co;
  logic [W-1:0]  m_next;

  assign ix       = i_q[AW-1:0];
  assign jx       = j_q[AW-1:0];
  assign jm1      = jx - AW'(1);
  assign s_m1     = s_q - SW'(1);
  assign sm1x     = s_m1[AW-1:0];
  assign start_ok = start_i && !busy_q && (s_i != '0) && (s_i <= SW'(S_MAX));
  // Only the low word matters: m makes the j=0 column vanish mod 2^W.
  assign m_next   = pe_s * pp0_q;

`ifdef FIOS_FINAL_SUB_EN
  assign diff = {1'b0, t_q[jx]} - {1'b0, p_q[jx]} - {{W{1'b0}}, brw_q};
`endif

  fios_pe_step #(.W(W), .CW(CW)) u_pe (
    .t_i (pe_t),
    .a_i (pe_a),
    .b_i (pe_b),
    .m_i (pe_m),
    .p_i (pe_p),
    .c_i (pe_c),
    .s_o (pe_s),
    .c_o (pe_co)
  );

  always_ff @(posedge clock_i) begin
    if (op_we_i && !busy_q) begin
      case (op_sel_i)
        OP_A:    a_q[op_addr_i] <= op_data_i;
        OP_B:    b_q[op_addr_i] <= op_data_i;
        OP_P:    p_q[op_addr_i] <= op_data_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    pp0_d   = pp0_q;
    i_d     = i_q;
    j_d     = j_q;
    m_d     = m_q;
    c_d     = c_q;
    t_d     = t_q;
    ttop_d  = ttop_q;
    busy_d  = done_q ? 1'b0 : busy_q;
    vld_d   = 1'b0;
    res_d   = '0;
    done_d  = 1'b0;
    pe_t    = '0;
    pe_a    = '0;
    pe_b    = '0;
    pe_m    = '0;
    pe_p    = '0;
    pe_c    = '0;
`ifdef FIOS_FINAL_SUB_EN
    d_d     = d_q;
    brw_d   = brw_q;
    use_d_d = use_d_q;
`endif
    case (state_q)
      IDLE: begin
        // The state is already IDLE during the done cycle; busy_q keeps a
        // start from being taken until busy_o has actually dropped.
        if (start_ok) begin
          s_d     = s_i;
          pp0_d   = p_prime_0_i;
          t_d     = '0;
          ttop_d  = '0;
          i_d     = '0;
          busy_d  = 1'b1;
          state_d = MCOMP;
        end
      end
      MCOMP: begin
        pe_t    = t_q[0];
        pe_a    = a_q[0];
        pe_b    = b_q[ix];
        m_d     = m_next;
        c_d     = '0;
        j_d     = '0;
        state_d = LOOP;
      end
      LOOP: begin
        pe_t = t_q[jx];
        pe_a = a_q[jx];
        pe_b = b_q[ix];
        pe_m = m_q;
        pe_p = p_q[jx];
        pe_c = c_q;
        c_d  = pe_co;
        // Column j lands in t[j-1]: the shift right by one word is the
        // division by 2^W. Column 0 is zero by construction of m.
        if (j_q != '0) t_d[jm1] = pe_s;
        if (j_q == s_m1) state_d = TAIL;
        else             j_d = j_q + SW'(1);
      end
      TAIL: begin
        pe_t         = {{(W-2){1'b0}}, ttop_q};
        pe_c         = c_q;
        t_d[sm1x]    = pe_s;
        ttop_d       = pe_co[1:0];
        i_d          = i_q + SW'(1);
        j_d          = '0;
        if (i_q + SW'(1) == s_q) begin
`ifdef FIOS_FINAL_SUB_EN
          brw_d   = 1'b0;
          state_d = SUB;
`else
          state_d = OUT;
`endif
        end else begin
          state_d = MCOMP;
        end
      end
`ifdef FIOS_FINAL_SUB_EN
      SUB: begin
        if (j_q == s_q) begin
          // Final borrow out of t[s]: t < p, keep t.
          use_d_d = !((ttop_q == 2'd0) && brw_q);
          j_d     = '0;
          state_d = OUT;
        end else begin
          d_d[jx] = diff[W-1:0];
          brw_d   = diff[W];
          j_d     = j_q + SW'(1);
        end
      end
`endif
      OUT: begin
        vld_d = 1'b1;
`ifdef FIOS_FINAL_SUB_EN
        res_d = use_d_q ? d_q[jx] : t_q[jx];
`else
        res_d = t_q[jx];
`endif
        if (j_q == s_m1) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          j_d = j_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      s_q     <= '0;
      pp0_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      m_q     <= '0;
      c_q     <= '0;
      t_q     <= '0;
      ttop_q  <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
`ifdef FIOS_FINAL_SUB_EN
      d_q     <= '0;
      brw_q   <= 1'b0;
      use_d_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      pp0_q   <= pp0_d;
      i_q     <= i_d;
      j_q     <= j_d;
      m_q     <= m_d;
      c_q     <= c_d;
      t_q     <= t_d;
      ttop_q  <= ttop_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      done_q  <= done_d;
`ifdef FIOS_FINAL_SUB_EN
      d_q     <= d_d;
      brw_q   <= brw_d;
      use_d_q <= use_d_d;
`endif
    end
  end

  assign busy_o      = busy_q;
  assign RES_valid_o = vld_q;
  assign RES_o       = res_q;
  assign done_o      = done_q;

endmodule
